// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and the
// one-bit full-subtractor equation.
package serial_sub_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Returns {borrow_out, diff} for a - b - borrow_in.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
        logic d;
        logic bout;
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
        return {bout, d};
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// Combinational one-bit full subtractor cell used by the serial datapath.
module full_subtractor_bit
    import serial_sub_pkg::*;
(
    input  logic a_in,
    input  logic b_in,
    input  logic borrow_in,
    output logic diff_out,
    output logic borrow_out
);

    assign {borrow_out, diff_out} = full_sub(a_in, b_in, borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a_in - b_in, LSB first, one full-subtractor cell per clock,
// with valid/ready handshakes on operand and result sides.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             overflow_out,
    output logic             busy_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic bit_diff;
    logic bit_borrow;
    logic accept_c;
    logic last_c;

    full_subtractor_bit u_cell (
        .a_in       (a_sr_q[0]),
        .b_in       (b_sr_q[0]),
        .borrow_in  (br_q),
        .diff_out   (bit_diff),
        .borrow_out (bit_borrow)
    );

    assign accept_c = (state_q == S_IDLE) && valid_in;
    assign last_c   = (state_q == S_SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c) state_d = S_SHIFT;
            S_SHIFT: if (last_c)   state_d = S_DONE;
            S_DONE:  if (ready_in) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so the flopped outputs track the state
    always_comb begin
        valid_d = (state_d == S_DONE);
        busy_d  = (state_d == S_SHIFT) || (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    // Serial datapath and result capture; results only change on entry to DONE
    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        if (accept_c) begin
            a_sr_d  = a_in;
            b_sr_d  = b_in;
            br_d    = 1'b0;
            cnt_d   = '0;
            a_msb_d = a_in[WIDTH-1];
            b_msb_d = b_in[WIDTH-1];
        end else if (state_q == S_SHIFT) begin
            a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
            res_d  = {bit_diff, res_q[WIDTH-1:1]};
            br_d   = bit_borrow;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last_c) begin
                diff_d   = {bit_diff, res_q[WIDTH-1:1]};
                borrow_d = bit_borrow;
                ovf_d    = (a_msb_q != b_msb_q) && (bit_diff != a_msb_q);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign diff_out     = diff_q;
    assign borrow_out   = borrow_q;
    assign overflow_out = ovf_q;
    assign valid_out    = valid_q;
    assign busy_out     = busy_q;
    assign ready_out    = ready_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 8;

    logic             clk_in;
    logic             rst_n_in;
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             valid_out;
    logic             ready_in;
    logic [WIDTH-1:0] diff_out;
    logic             borrow_out;
    logic             overflow_out;
    logic             busy_out;

    int n_tests = 0;
    int n_fail  = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .a_in         (a_in),
        .b_in         (b_in),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .diff_out     (diff_out),
        .borrow_out   (borrow_out),
        .overflow_out (overflow_out),
        .busy_out     (busy_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full operation: accept, wait for result with latency check, hand off.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ed, input logic eb, input logic eo,
                          input logic early_rdy);
        int n;
        @(negedge clk_in);
        check_val({tag, "_ready"}, 32'(ready_out), 32'd1);
        a_in     = a;
        b_in     = b;
        valid_in = 1'b1;
        ready_in = early_rdy;
        @(posedge clk_in);
        @(negedge clk_in);
        valid_in = 1'b0;
        check_val({tag, "_busy"}, 32'(busy_out), 32'd1);
        n = 0;
        while (!valid_out && n < 20) begin
            @(posedge clk_in);
            n++;
            @(negedge clk_in);
        end
        check_val({tag, "_latency"}, 32'(n), 32'd8);
        check_val({tag, "_diff"}, 32'(diff_out), 32'(ed));
        check_val({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
        check_val({tag, "_ovf"}, 32'(overflow_out), 32'(eo));
        ready_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        ready_in = 1'b0;
        check_val({tag, "_vdrop"}, 32'(valid_out), 32'd0);
        check_val({tag, "_idle"}, 32'(ready_out), 32'd1);
        check_val({tag, "_hold"}, 32'(diff_out), 32'(ed));
    endtask

    initial begin
        rst_n_in = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        a_in     = '0;
        b_in     = '0;
        repeat (2) @(negedge clk_in);
        check_val("rst_ready", 32'(ready_out), 32'd1);
        check_val("rst_valid", 32'(valid_out), 32'd0);
        check_val("rst_busy", 32'(busy_out), 32'd0);
        check_val("rst_diff", 32'(diff_out), 32'd0);
        rst_n_in = 1'b1;

        run_op("t2", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b0);
        // ready_in held high from accept: must not shorten or disturb the op
        run_op("t3a", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b1);
        run_op("t3b", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op("t4a", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        // 127 < 255 unsigned, so a borrow is produced
        run_op("t4b", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
        run_op("eq", 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0);

        // Stall in DONE with ready_in low; valid_in pulses must be ignored
        @(negedge clk_in);
        a_in = 8'h55; b_in = 8'h0F; valid_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        a_in = 8'hAA; b_in = 8'h01;
        for (int i = 0; i < 20 && !valid_out; i++) @(negedge clk_in);
        check_val("t5_valid", 32'(valid_out), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check_val("t5_stable_diff", 32'(diff_out), 32'h46);
            check_val("t5_stable_valid", 32'(valid_out), 32'd1);
            check_val("t5_no_ready", 32'(ready_out), 32'd0);
        end
        // Handoff cycle with valid_in still high: capture only in the next IDLE cycle
        ready_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        ready_in = 1'b0;
        check_val("t5_idle_ready", 32'(ready_out), 32'd1);
        check_val("t5_idle_busy", 32'(busy_out), 32'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        valid_in = 1'b0;
        check_val("t5_next_busy", 32'(busy_out), 32'd1);
        for (int i = 0; i < 20 && !valid_out; i++) @(negedge clk_in);
        check_val("t5_next_diff", 32'(diff_out), 32'hA9);
        check_val("t5_next_borrow", 32'(borrow_out), 32'd0);
        check_val("t5_next_ovf", 32'(overflow_out), 32'd0);

        // Asynchronous reset in the middle of a DONE phase
        @(posedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        check_val("t1_async_diff", 32'(diff_out), 32'd0);
        check_val("t1_async_valid", 32'(valid_out), 32'd0);
        check_val("t1_async_ready", 32'(ready_out), 32'd1);
        check_val("t1_async_borrow", 32'(borrow_out), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Reset after the third SHIFT edge aborts the operation
        @(negedge clk_in);
        a_in = 8'h12; b_in = 8'h34; valid_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        valid_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        check_val("t6_ready", 32'(ready_out), 32'd1);
        check_val("t6_busy", 32'(busy_out), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        run_op("t6_ff", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
